iob_timer_sampler: RTL and testbench
====================================

# iob_timer_sampler

Hardware initiator on the IOb native bus that drives the timer peripheral's software registers without CPU involvement. On single-cycle command pulses it issues the required register-write/read sequences: soft-reset and start, stop, and atomic 64-bit sample and readback. It sits between an event source, such as a trigger or capture logic, and the timer's IOb slave port. It returns timestamps on a valid-pulsed output.

## Interface
- ADDR_W, 5: IOb address width.
- DATA_W, 32: IOb data width; timestamp is 2*DATA_W.
- RESET_ADDR, 0: address of TIMER_RESET register.
- ENABLE_ADDR, 4: address of TIMER_ENABLE register.
- SAMPLE_ADDR, 8: address of TIMER_SAMPLE register.
- DATA_LOW_ADDR, 12: address of TIMER_DATA_LOW register.
- DATA_HIGH_ADDR, 16: address of TIMER_DATA_HIGH register.
- TIMEOUT_W, 8: width of ready-timeout counter; a transaction aborts after 2^TIMEOUT_W-1 cycles without ready.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset; one clock, asynchronous active-low reset.
- start_i  in  1  command: soft-reset timer, then enable.
- stop_i  in  1  command: disable timer.
- sample_i  in  1  command: sample and read 64-bit value.
- busy_o  out  1  sequence in progress; commands ignored.
- ts_o  out  2*DATA_W  last sampled timer value.
- ts_valid_o  out  1  one-cycle pulse: ts_o updated.
- error_o  out  1  one-cycle pulse: transaction timed out, sequence aborted.
- iob_valid_o  out  1  request valid.
- iob_addr_o  out  ADDR_W  request address.
- iob_wdata_o  out  DATA_W  write data.
- iob_wstrb_o  out  DATA_W/8  byte strobes; all-ones is a write, zero is a read.
- iob_rdata_i  in  DATA_W  read data, valid when iob_ready_i is high.
- iob_ready_i  in  1  transaction complete.

## Operation
- Bus rule:
  - iob_valid_o and the request fields are registered.
  - They are held stable until a cycle with iob_ready_i=1; that cycle completes the transaction.
  - iob_ready_i is ignored while iob_valid_o=0.
- Command acceptance: a command is accepted only in IDLE; a command seen while busy_o=1 is dropped.
- Simultaneous commands: priority start > stop > sample; lower-priority commands in the same cycle are dropped.
- FSM states: IDLE, RST_HI, RST_LO, EN_HI, EN_OFF, SMP_HI, RD_LO, RD_HI, SMP_LO, DONE.
- Each bus state issues one transaction and advances on ready:
  - start: RST_HI (write 1 to RESET) -> RST_LO (write 0 to RESET) -> EN_HI (write 1 to ENABLE) -> IDLE.
  - stop: EN_OFF (write 0 to ENABLE) -> IDLE.
  - sample: SMP_HI (write 1 to SAMPLE) -> RD_LO (read DATA_LOW, capture into low shadow) -> RD_HI (read DATA_HIGH, capture into high shadow) -> SMP_LO (write 0 to SAMPLE) -> DONE -> IDLE.
- DONE: copies both shadows to ts_o and pulses ts_valid_o. ts_o otherwise holds its value.
- Write data: bit 0 carries the value, upper bits are 0, iob_wstrb_o is all-ones.
- Reads: iob_wdata_o=0, iob_wstrb_o=0.
- busy_o=1 in every state except IDLE.
- Timeout counter:
  - Cleared at each transaction issue; increments while iob_valid_o=1 and iob_ready_i=0.
  - On reaching all-ones: drop iob_valid_o, pulse error_o, return to IDLE.
  - ts_o is unchanged; shadows are discarded.
- Reset values: all outputs 0, FSM in IDLE, shadows and timeout counter 0.

## Timing
- Command accepted at edge N; iob_valid_o=1 with the first transaction from cycle N+1.
- Transaction completing at cycle M (ready=1): the next transaction's fields appear at cycle M+1. iob_valid_o stays high across back-to-back transactions, with no idle cycle.
- Against a responder with ready one cycle after valid, each transaction takes 2 cycles:
  - sample: ts_valid_o high at cycle N+9.
  - start: busy_o low at cycle N+7.
  - stop: busy_o low at cycle N+3.
- Against a zero-wait responder (ready in the same cycle as valid), each transaction takes 1 cycle.
- busy_o is registered: high from N+1 to the cycle after the last ready. A new command is accepted in the first cycle busy_o=0.
- error_o pulse: the cycle after the counter saturates; iob_valid_o is low in that same cycle.
- arst_n assertion mid-transaction: all outputs go to 0 immediately (asynchronously), FSM returns to IDLE, and no completion is reported.

## Test plan
- start_i pulse, 1-wait responder:
  - Writes in order: RESET=1, RESET=0, ENABLE=1 at addresses 0, 0, 4.
  - busy_o falls at N+7.
- sample_i, responder returns DATA_LOW=0xDEADBEEF, DATA_HIGH=0x00000001:
  - Bus sequence: write SAMPLE=1, read 12, read 16, write SAMPLE=0.
  - ts_o=0x00000001_DEADBEEF; ts_valid_o single pulse at N+9.
- start_i and sample_i in the same cycle: only the start sequence executes.
  - sample_i pulsed while busy_o=1: no extra transactions.
- Responder never asserts ready with TIMEOUT_W=4 during sample: error_o pulses after 15 stalled cycles, FSM returns to IDLE, ts_o retains its prior value, ts_valid_o stays 0.
- arst_n low during RD_HI, then released and sample_i issued: outputs are 0 during reset, and the new sample completes normally with fresh data.
- Zero-wait responder, sample: four consecutive single-cycle transactions with iob_valid_o continuously high; ts_valid_o at N+5.

Source files
------------

// File: rtl/iob_timer_sampler.sv
// IOb bus initiator that sequences the timer peripheral's registers:
// soft-reset + enable, disable, and atomic 64-bit sample/readback.
//
// state  | meaning
// IDLE   | waiting for a command
// RST_HI | write 1 to TIMER_RESET
// RST_LO | write 0 to TIMER_RESET
// EN_HI  | write 1 to TIMER_ENABLE
// EN_OFF | write 0 to TIMER_ENABLE
// SMP_HI | write 1 to TIMER_SAMPLE (freeze counter copy)
// RD_LO  | read TIMER_DATA_LOW into low shadow
// RD_HI  | read TIMER_DATA_HIGH into high shadow
// SMP_LO | write 0 to TIMER_SAMPLE
// DONE   | timestamp published, back to IDLE
module iob_timer_sampler #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int RESET_ADDR     = 0,
  parameter int ENABLE_ADDR    = 4,
  parameter int SAMPLE_ADDR    = 8,
  parameter int DATA_LOW_ADDR  = 12,
  parameter int DATA_HIGH_ADDR = 16,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  sample_i,
  output logic                  busy_o,
  output logic [2*DATA_W-1:0]   ts_o,
  output logic                  ts_valid_o,
  output logic                  error_o,
  output logic                  iob_valid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  input  logic                  iob_ready_i
);

  typedef enum logic [3:0] {
    IDLE, RST_HI, RST_LO, EN_HI, EN_OFF, SMP_HI, RD_LO, RD_HI, SMP_LO, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_RST = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] A_EN  = ADDR_W'(ENABLE_ADDR);
  localparam logic [ADDR_W-1:0] A_SMP = ADDR_W'(SAMPLE_ADDR);
  localparam logic [ADDR_W-1:0] A_LO  = ADDR_W'(DATA_LOW_ADDR);
  localparam logic [ADDR_W-1:0] A_HI  = ADDR_W'(DATA_HIGH_ADDR);

  state_t                state_q, state_d;
  logic                  busy_q, ts_valid_q, error_q;
  logic                  iob_valid_q;
  logic [ADDR_W-1:0]     iob_addr_q;
  logic [DATA_W-1:0]     iob_wdata_q;
  logic [DATA_W/8-1:0]   iob_wstrb_q;
  logic [DATA_W-1:0]     lo_q, hi_q;
  logic [2*DATA_W-1:0]   ts_q;
  logic [TIMEOUT_W-1:0]  tmo_q, tmo_d;

  logic                  xfer_done, stall, tmo_expire;
  logic                  req_bus, req_write, req_bit;
  logic [ADDR_W-1:0]     req_addr;

  assign xfer_done  = iob_valid_q && iob_ready_i;
  assign stall      = iob_valid_q && !iob_ready_i;
  assign tmo_d      = tmo_q + 1'b1;
  // Abort on the stalled cycle that drives the counter to all-ones.
  assign tmo_expire = stall && (tmo_d == {TIMEOUT_W{1'b1}});

  // Next state: commands only in IDLE, bus states advance on ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i)       state_d = RST_HI;
        else if (stop_i)   state_d = EN_OFF;
        else if (sample_i) state_d = SMP_HI;
      end
      DONE: state_d = IDLE;
      default: begin
        if (xfer_done) begin
          case (state_q)
            RST_HI:  state_d = RST_LO;
            RST_LO:  state_d = EN_HI;
            SMP_HI:  state_d = RD_LO;
            RD_LO:   state_d = RD_HI;
            RD_HI:   state_d = SMP_LO;
            SMP_LO:  state_d = DONE;
            default: state_d = IDLE;
          endcase
        end else if (tmo_expire) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Request fields for the transaction the next state will issue.
  always_comb begin
    req_bus   = 1'b1;
    req_write = 1'b1;
    req_bit   = 1'b0;
    req_addr  = '0;
    case (state_d)
      RST_HI: begin req_addr = A_RST; req_bit = 1'b1; end
      RST_LO: req_addr = A_RST;
      EN_HI:  begin req_addr = A_EN; req_bit = 1'b1; end
      EN_OFF: req_addr = A_EN;
      SMP_HI: begin req_addr = A_SMP; req_bit = 1'b1; end
      SMP_LO: req_addr = A_SMP;
      RD_LO:  begin req_addr = A_LO; req_write = 1'b0; end
      RD_HI:  begin req_addr = A_HI; req_write = 1'b0; end
      default: begin req_bus = 1'b0; req_write = 1'b0; end
    endcase
  end

  // Sequencer registers: state, bus request, shadows, timestamp, pulses.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      ts_valid_q  <= 1'b0;
      error_q     <= 1'b0;
      iob_valid_q <= 1'b0;
      iob_addr_q  <= '0;
      iob_wdata_q <= '0;
      iob_wstrb_q <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      ts_q        <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != IDLE);
      ts_valid_q  <= 1'b0;
      error_q     <= 1'b0;
      iob_valid_q <= req_bus;
      // Every bus state differs from its predecessor, so a state change
      // into a bus state marks a new transaction.
      if (req_bus && (state_d != state_q)) begin
        iob_addr_q  <= req_addr;
        iob_wdata_q <= {{(DATA_W-1){1'b0}}, req_bit};
        iob_wstrb_q <= {(DATA_W/8){req_write}};
        tmo_q       <= '0;
      end else if (stall) begin
        tmo_q <= tmo_d;
      end
      if (xfer_done && state_q == RD_LO) lo_q <= iob_rdata_i;
      if (xfer_done && state_q == RD_HI) hi_q <= iob_rdata_i;
      // Publish when the closing SAMPLE=0 write completes so the pulse
      // lands in the DONE cycle.
      if (xfer_done && state_q == SMP_LO) begin
        ts_q       <= {hi_q, lo_q};
        ts_valid_q <= 1'b1;
      end
      if (tmo_expire) begin
        error_q <= 1'b1;
        lo_q    <= '0;
        hi_q    <= '0;
      end
    end
  end

  assign busy_o      = busy_q;
  assign ts_o        = ts_q;
  assign ts_valid_o  = ts_valid_q;
  assign error_o     = error_q;
  assign iob_valid_o = iob_valid_q;
  assign iob_addr_o  = iob_addr_q;
  assign iob_wdata_o = iob_wdata_q;
  assign iob_wstrb_o = iob_wstrb_q;

endmodule

// File: tb/tb_iob_timer_sampler.sv
// Bench for iob_timer_sampler: scoreboarded bus transactions and timestamps,
// plus cycle-accurate latency checks per command.
module tb_iob_timer_sampler;

  localparam int TW = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start_i = 1'b0, stop_i = 1'b0, sample_i = 1'b0;
  logic        busy_o, ts_valid_o, error_o, iob_valid_o, iob_ready_i;
  logic [63:0] ts_o;
  logic [4:0]  iob_addr_o;
  logic [31:0] iob_wdata_o, iob_rdata_i;
  logic [3:0]  iob_wstrb_o;

  iob_timer_sampler #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .arst_n(arst_n),
    .start_i(start_i), .stop_i(stop_i), .sample_i(sample_i),
    .busy_o(busy_o), .ts_o(ts_o), .ts_valid_o(ts_valid_o), .error_o(error_o),
    .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o),
    .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
    .iob_rdata_i(iob_rdata_i), .iob_ready_i(iob_ready_i)
  );

  always #5 clk = ~clk;

  // responder: mode 0 zero-wait, 1 one-wait, 2 never ready
  int          mode = 1;
  logic        rdy_q = 1'b0;
  logic [31:0] lo_val = '0, hi_val = '0;

  always @(posedge clk) rdy_q <= iob_valid_o && !rdy_q;
  assign iob_ready_i = (mode == 0) ? iob_valid_o : (mode == 1) ? (rdy_q && iob_valid_o) : 1'b0;
  assign iob_rdata_i = (iob_addr_o == 5'd12) ? lo_val : (iob_addr_o == 5'd16) ? hi_val : 32'h0;

  typedef struct packed { logic [4:0] a; logic [31:0] d; logic [3:0] s; } tx_t;
  tx_t         exp_q[$];
  logic [63:0] ts_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_w(input logic [4:0] a, input logic b);
    tx_t t;
    t.a = a; t.d = {31'd0, b}; t.s = 4'hF;
    exp_q.push_back(t);
  endfunction

  function automatic void push_r(input logic [4:0] a);
    tx_t t;
    t.a = a; t.d = '0; t.s = 4'h0;
    exp_q.push_back(t);
  endfunction

  function automatic void push_sample(input logic [31:0] lo, input logic [31:0] hi);
    push_w(5'd8, 1'b1); push_r(5'd12); push_r(5'd16); push_w(5'd8, 1'b0);
    ts_q.push_back({hi, lo});
  endfunction

  // monitor: completed transactions and timestamp pulses against scoreboard
  always @(negedge clk) begin
    if (arst_n && iob_valid_o && iob_ready_i) begin
      tx_t got;
      got.a = iob_addr_o; got.d = iob_wdata_o; got.s = iob_wstrb_o;
      if (exp_q.size() == 0) chk("unexpected_tx", 64'(got), 64'h0);
      else chk("bus_tx", 64'(got), 64'(exp_q.pop_front()));
    end
    if (arst_n && ts_valid_o) begin
      if (ts_q.size() == 0) chk("unexpected_ts", ts_o, 64'h0);
      else chk("ts_value", ts_o, ts_q.pop_front());
    end
  end

  // Pulse commands at edge N, then watch cycles N+1.. for events.
  task automatic run_cmd(input logic s, input logic p, input logic m, input bit inject,
                         output int t_busy, output int t_tsv, output int n_tsv,
                         output int t_err, output int n_valid4);
    t_busy = -1; t_tsv = -1; n_tsv = 0; t_err = -1; n_valid4 = 0;
    @(negedge clk);
    start_i = s; stop_i = p; sample_i = m;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start_i = 1'b0; stop_i = 1'b0; sample_i = 1'b0;
      if (inject && k == 3) sample_i = 1'b1;
      if (t_busy < 0 && !busy_o) t_busy = k;
      if (ts_valid_o) begin n_tsv++; if (t_tsv < 0) t_tsv = k; end
      if (error_o && t_err < 0) begin
        t_err = k;
        chk("valid_low_at_error", 64'(iob_valid_o), 64'h0);
      end
      if (iob_valid_o && (k <= 4 || t_err < 0 && mode == 2)) n_valid4++;
    end
  endtask

  int tb, tt, nt, te, nv;
  bit found;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_valid", 64'(iob_valid_o), 0);
    chk("rst_ts", ts_o, 0);
    chk("rst_tsv", 64'(ts_valid_o), 0);
    chk("rst_err", 64'(error_o), 0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // start, one-wait responder
    mode = 1;
    push_w(5'd0, 1'b1); push_w(5'd0, 1'b0); push_w(5'd4, 1'b1);
    run_cmd(1, 0, 0, 0, tb, tt, nt, te, nv);
    chk("start_busy_fall", 64'(tb), 7);
    chk("start_q_empty", 64'(exp_q.size()), 0);

    // stop
    push_w(5'd4, 1'b0);
    run_cmd(0, 1, 0, 0, tb, tt, nt, te, nv);
    chk("stop_busy_fall", 64'(tb), 3);
    chk("stop_q_empty", 64'(exp_q.size()), 0);

    // sample
    lo_val = 32'hDEADBEEF; hi_val = 32'h00000001;
    push_sample(lo_val, hi_val);
    run_cmd(0, 0, 1, 0, tb, tt, nt, te, nv);
    chk("smp_tsv_cycle", 64'(tt), 9);
    chk("smp_tsv_count", 64'(nt), 1);
    chk("smp_busy_fall", 64'(tb), 10);
    chk("smp_ts_hold", ts_o, 64'h00000001_DEADBEEF);
    chk("smp_q_empty", 64'(exp_q.size() + ts_q.size()), 0);

    // start and sample together, plus sample while busy: start only
    push_w(5'd0, 1'b1); push_w(5'd0, 1'b0); push_w(5'd4, 1'b1);
    run_cmd(1, 0, 1, 1, tb, tt, nt, te, nv);
    chk("prio_busy_fall", 64'(tb), 7);
    chk("prio_no_tsv", 64'(nt), 0);
    chk("prio_q_empty", 64'(exp_q.size()), 0);

    // timeout during sample
    mode = 2;
    run_cmd(0, 0, 1, 0, tb, tt, nt, te, nv);
    chk("tmo_err_cycle", 64'(te), 16);
    chk("tmo_valid_cycles", 64'(nv), 15);
    chk("tmo_no_tsv", 64'(nt), 0);
    chk("tmo_busy_fall", 64'(tb), 16);
    chk("tmo_ts_kept", ts_o, 64'h00000001_DEADBEEF);

    // reset asserted during RD_HI
    mode = 1;
    lo_val = 32'h11111111; hi_val = 32'h22222222;
    push_w(5'd8, 1'b1); push_r(5'd12);
    @(negedge clk); sample_i = 1'b1;
    @(negedge clk); sample_i = 1'b0;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (iob_valid_o && iob_addr_o == 5'd16) found = 1;
      else @(negedge clk);
    end
    chk("reached_rd_hi", 64'(found), 1);
    arst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(iob_valid_o), 0);
    chk("arst_busy", 64'(busy_o), 0);
    chk("arst_ts", ts_o, 0);
    chk("arst_addr", 64'(iob_addr_o), 0);
    chk("arst_q_empty", 64'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
    chk("arst_tsv", 64'(ts_valid_o), 0);
    arst_n = 1'b1;
    @(negedge clk);
    lo_val = 32'h12345678; hi_val = 32'hCAFEF00D;
    push_sample(lo_val, hi_val);
    run_cmd(0, 0, 1, 0, tb, tt, nt, te, nv);
    chk("post_rst_tsv_cycle", 64'(tt), 9);
    chk("post_rst_ts", ts_o, 64'hCAFEF00D_12345678);

    // zero-wait sample
    mode = 0;
    lo_val = 32'hA5A5_0F0F; hi_val = 32'h8000_0003;
    push_sample(lo_val, hi_val);
    run_cmd(0, 0, 1, 0, tb, tt, nt, te, nv);
    chk("zw_tsv_cycle", 64'(tt), 5);
    chk("zw_valid_cont", 64'(nv), 4);
    chk("zw_busy_fall", 64'(tb), 6);
    chk("zw_q_empty", 64'(exp_q.size() + ts_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
